mem_data_arb: RTL and testbench

- Two-requester arbiter in front of the single-port data memory (mem_data).
- Port 0 is the core load/store unit; port 1 is the loader/debug port.
- Grants at most one access per cycle, round-robin, and muxes the winner's command onto the memory pins.
- Returns read data with the memory's one-cycle read latency, tagged to the requester that issued the read.

---
 rtl/mem_data_arb_pkg.sv | 14 +
 rtl/mem_data_arb_rr.sv | 27 ++
 rtl/mem_data_arb.sv | 165 ++++++++++++++++
 tb/tb_mem_data_arb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_data_arb_pkg.sv
// mem_data_arb_pkg: shared constants for the data-memory arbiter.
//   ADDR_DEF / WORD_DEF : default address / data widths for the data memory
//   LOCK_CNT_W          : width of the lock-ownership cycle counter
//   P0 / P1             : port indices (P0 = load/store unit, P1 = loader/debug)
package mem_data_arb_pkg;

    localparam int unsigned ADDR_DEF   = 8;
    localparam int unsigned WORD_DEF   = 8;
    localparam int unsigned LOCK_CNT_W = 4;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/mem_data_arb_rr.sv
// mem_data_arb_rr: 2-way round-robin picker.
//   req0, req1 : requests (already filtered by any ownership rule)
//   last       : port granted most recently
//   winner_c   : index of the winning port (P0 when nobody requests)
//   any_c      : at least one request present
module mem_data_arb_rr
    import mem_data_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner_c,
    output logic any_c
);

    // On contention the port that did not win last time goes first.
    always_comb begin
        any_c    = req0 | req1;
        winner_c = P0;
        if (req0 && req1) begin
            winner_c = ~last;
        end else if (req1) begin
            winner_c = P1;
        end
    end

endmodule

// File: rtl/mem_data_arb.sv
// mem_data_arb: two-requester round-robin arbiter in front of the
// single-port data memory (1-cycle read latency).
//   clk, rst            : clock, asynchronous active-low reset
//   req/we/addr/wdata/lockX : requester X command, held until gntX
//   gnt0, gnt1          : combinational grant
//   rvalid0, rvalid1    : registered; rdata holds that port's read result
//   rdata               : shared read return (mem_q)
//   mem_a/mem_w/mem_d   : command to memory, mem_q : memory read data
// Optional build macro MEM_ARB_LOCK_EN: lockX keeps port X as exclusive
// owner until an unlocked access or LOCK_MAX owned cycles elapse.
module mem_data_arb
    import mem_data_arb_pkg::*;
#(
    parameter int unsigned ADDR     = ADDR_DEF,
    parameter int unsigned WORD     = WORD_DEF,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [ADDR-1:0] addr0,
    input  logic [ADDR-1:0] addr1,
    input  logic [WORD-1:0] wdata0,
    input  logic [WORD-1:0] wdata1,
    input  logic            lock0,
    input  logic            lock1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [WORD-1:0] rdata,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    logic last;
    logic last_nxt;
    logic winner_c;
    logic any_c;
    logic req0_eff_c;
    logic req1_eff_c;
    logic force_rel_c;
    logic rel_owner_c;

`ifdef MEM_ARB_LOCK_EN
    localparam logic [0:0] ST_FREE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic                  owner;
    logic                  owner_nxt;
    logic [LOCK_CNT_W-1:0] cnt;
    logic [LOCK_CNT_W-1:0] cnt_nxt;
    logic                  win_lock_c;

    // While owned, only the owner's request is visible to the picker.
    assign req0_eff_c  = req0 & ((state == ST_FREE) | (owner == P0));
    assign req1_eff_c  = req1 & ((state == ST_FREE) | (owner == P1));
    assign win_lock_c  = (winner_c == P1) ? lock1 : lock0;
    assign rel_owner_c = owner;

    // Lock FSM: take ownership on a locked grant, release on an unlocked
    // owner access or when the owned-cycle counter hits LOCK_MAX.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        force_rel_c = 1'b0;
        case (state)
            ST_FREE: begin
                if (any_c && win_lock_c) begin
                    state_nxt = ST_OWNED;
                    owner_nxt = winner_c;
                    cnt_nxt   = '0;
                end
            end
            ST_OWNED: begin
                cnt_nxt = LOCK_CNT_W'(cnt + 1'b1);
                if (cnt_nxt == LOCK_CNT_W'(LOCK_MAX)) begin
                    force_rel_c = 1'b1;
                    state_nxt   = ST_FREE;
                end else if (any_c && (winner_c == owner) && !win_lock_c) begin
                    state_nxt = ST_FREE;
                end
            end
            default: state_nxt = ST_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FREE;
            owner <= P0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end
`else
    logic unused_lock;

    assign req0_eff_c  = req0;
    assign req1_eff_c  = req1;
    assign force_rel_c = 1'b0;
    assign rel_owner_c = P0;
    assign unused_lock = ^{lock0, lock1, LOCK_CNT_W'(LOCK_MAX)};
`endif

    mem_data_arb_rr u_rr (
        .req0     (req0_eff_c),
        .req1     (req1_eff_c),
        .last     (last),
        .winner_c (winner_c),
        .any_c    (any_c)
    );

    assign gnt0  = any_c & (winner_c == P0);
    assign gnt1  = any_c & (winner_c == P1);
    assign rdata = mem_q;

    // Memory command mux; port 0 values drive the bus when idle.
    always_comb begin
        mem_a = addr0;
        mem_d = wdata0;
        mem_w = 1'b0;
        if (gnt1) begin
            mem_a = addr1;
            mem_d = wdata1;
            mem_w = we1;
        end else if (gnt0) begin
            mem_w = we0;
        end
    end

    // A forced release hands priority away from the former owner.
    always_comb begin
        last_nxt = last;
        if (force_rel_c) begin
            last_nxt = rel_owner_c;
        end else if (any_c) begin
            last_nxt = winner_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last    <= P1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            last    <= last_nxt;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

endmodule

// File: tb/tb_mem_data_arb.sv
// tb_mem_data_arb: directed, scoreboard-checked bench for mem_data_arb with
// a behavioural single-port memory (1-cycle read, o_reg holds on write).
module tb_mem_data_arb;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_a;
    logic          mem_w;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    // expected read returns: {port, data}
    logic [DW:0] sb [$];

    always #5 clk = ~clk;

    mem_data_arb #(.ADDR(AW), .WORD(DW), .LOCK_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d),
        .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (mem_w) mem[mem_a] <= mem_d;
        else       mem_q <= mem[mem_a];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every rvalid pops and checks the oldest expected read.
    always @(negedge clk) begin
        if (rst === 1'b1 && (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)) begin
            if (rvalid0 === 1'b1 && rvalid1 === 1'b1) begin
                chk("rvalid_both", 32'(2'b11), 32'(2'b01));
            end else if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'({rvalid1, rvalid0}), 32'(0));
            end else begin
                logic [DW:0] e;
                e = sb.pop_front();
                chk("rvalid_port", 32'(rvalid1), 32'(e[DW]));
                chk("rdata", 32'(rdata), 32'(e[DW-1:0]));
            end
        end
    end

    // One cycle of stimulus with the expected grant and read data.
    task automatic step(input string nm,
                        input logic r0, w0, input logic [7:0] a0, d0, input logic l0,
                        input logic r1, w1, input logic [7:0] a1, d1, input logic l1,
                        input logic eg0, eg1, input logic [7:0] erd);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        @(negedge clk);
        chk({nm, ".gnt0"}, 32'(gnt0), 32'(eg0));
        chk({nm, ".gnt1"}, 32'(gnt1), 32'(eg1));
        if (eg1) begin
            chk({nm, ".mem_a"}, 32'(mem_a), 32'(a1));
            chk({nm, ".mem_w"}, 32'(mem_w), 32'(w1));
            if (w1) chk({nm, ".mem_d"}, 32'(mem_d), 32'(d1));
            else    sb.push_back({1'b1, erd});
        end else if (eg0) begin
            chk({nm, ".mem_a"}, 32'(mem_a), 32'(a0));
            chk({nm, ".mem_w"}, 32'(mem_w), 32'(w0));
            if (w0) chk({nm, ".mem_d"}, 32'(mem_d), 32'(d0));
            else    sb.push_back({1'b0, erd});
        end else begin
            chk({nm, ".mem_w_idle"}, 32'(mem_w), 32'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 0,0,8'h00,8'h00,0, 0,0,8'h00,8'h00,0, 0,0,8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset.rvalid0", 32'(rvalid0), 32'(0));
        chk("reset.rvalid1", 32'(rvalid1), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single port write then read back
        step("t1_wr", 1,1,8'h03,8'hA5,0, 0,0,8'h00,8'h00,0, 1,0,8'h00);
        step("t1_rd", 1,0,8'h03,8'h00,0, 0,0,8'h00,8'h00,0, 1,0,8'hA5);
        idle("t1_idle");

        // preload, leaving port 1 as last winner
        step("su_wr0", 1,1,8'h05,8'h77,0, 0,0,8'h00,8'h00,0, 1,0,8'h00);
        step("su_wr1", 0,0,8'h00,8'h00,0, 1,1,8'h04,8'h3C,0, 0,1,8'h00);

        // continuous contention alternates 0,1,0,1,0,1
        step("t2_c0", 1,0,8'h03,8'h00,0, 1,0,8'h04,8'h00,0, 1,0,8'hA5);
        step("t2_c1", 1,0,8'h05,8'h00,0, 1,0,8'h04,8'h00,0, 0,1,8'h3C);
        step("t2_c2", 1,0,8'h05,8'h00,0, 1,0,8'h04,8'h00,0, 1,0,8'h77);
        step("t2_c3", 1,0,8'h03,8'h00,0, 1,0,8'h04,8'h00,0, 0,1,8'h3C);
        step("t2_c4", 1,0,8'h03,8'h00,0, 1,0,8'h04,8'h00,0, 1,0,8'hA5);
        step("t2_c5", 1,0,8'h05,8'h00,0, 1,0,8'h04,8'h00,0, 0,1,8'h3C);

        // read-after-write across ports
        step("t3_wr1", 0,0,8'h00,8'h00,0, 1,1,8'h02,8'h11,0, 0,1,8'h00);
        step("t3_rd0", 1,0,8'h02,8'h00,0, 0,0,8'h00,8'h00,0, 1,0,8'h11);
        idle("t3_idle");

        // reset between read grant and rvalid drops the return
        step("t4_rd0", 1,0,8'h03,8'h00,0, 0,0,8'h00,8'h00,0, 1,0,8'hA5);
        void'(sb.pop_back());
        chk("t4.rvalid0_pre", 32'(rvalid0), 32'(1));
        req0 = 0;
        rst  = 1'b0;
        #1;
        chk("t4.rvalid0_async", 32'(rvalid0), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("t4_c0", 1,0,8'h05,8'h00,0, 1,0,8'h04,8'h00,0, 1,0,8'h77);
        step("t4_c1", 0,0,8'h00,8'h00,0, 1,0,8'h04,8'h00,0, 0,1,8'h3C);
        idle("t4_idle");

`ifdef MEM_ARB_LOCK_EN
        // locked read-modify-write blocks port 1 until the unlocking write
        step("l1_rd",  1,0,8'h03,8'h00,1, 1,0,8'h04,8'h00,0, 1,0,8'hA5);
        step("l1_wr",  1,1,8'h06,8'h99,0, 1,0,8'h04,8'h00,0, 1,0,8'h00);
        step("l1_p1",  0,0,8'h00,8'h00,0, 1,0,8'h04,8'h00,0, 0,1,8'h3C);
        idle("l1_idle");

        // lock held forever is released after LOCK_MAX owned cycles
        for (int i = 0; i < 4; i++) begin
            step($sformatf("l2_own%0d", i), 1,0,8'h06,8'h00,1, 1,0,8'h04,8'h00,0, 1,0,8'h99);
        end
        step("l2_p1", 1,0,8'h06,8'h00,1, 1,0,8'h04,8'h00,0, 0,1,8'h3C);
        idle("l2_idle");
`endif

        idle("drain0");
        idle("drain1");
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
